// File: rtl/mux_rr_sel_arbiter_if.sv
// Request/select bundle between the four sources, the round-robin arbiter and the 4:1 mux consumer.
// With MUX_ARB_LOCK_EN defined the bundle also carries the lock input.
interface mux_rr_sel_arbiter_if #(
  parameter int CNT_W = 8
);
  logic [3:0]       req;
  logic             ready;
`ifdef MUX_ARB_LOCK_EN
  logic             lock;
`endif
  logic [1:0]       sel;
  logic [3:0]       grant;
  logic             valid;
  logic [CNT_W-1:0] beat;

  // Arbiter side.
  modport master (
    input  req,
    input  ready,
`ifdef MUX_ARB_LOCK_EN
    input  lock,
`endif
    output sel,
    output grant,
    output valid,
    output beat
  );

  // Sources and consumer side.
  modport slave (
    output req,
    output ready,
`ifdef MUX_ARB_LOCK_EN
    output lock,
`endif
    input  sel,
    input  grant,
    input  valid,
    input  beat
  );
endinterface

// File: rtl/mux_rr_sel_arbiter.sv
// Round-robin arbiter driving the 2-bit select of a 4:1 mux, with a per-grant beat dwell limit.
// Optional MUX_ARB_LOCK_EN adds a lock input that suspends dwell expiry while asserted.
module mux_rr_sel_arbiter #(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mux_rr_sel_arbiter_if.master  bus
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [CNT_W-1:0] DWELL_M1 = CNT_W'(DWELL - 1);

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       last_q, last_d;
  logic [3:0]       grant_q, grant_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] beat_q, beat_d;

  logic [2:0]       pick;
  logic             xfer;
  logic             at_dwell;
  logic             drop;
  logic             expire;

  // Returns {found, index}: first set request at or after last+1, wrapping once.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!res[2] && r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    last_d   = last_q;
    grant_d  = grant_q;
    valid_d  = valid_q;
    beat_d   = beat_q;
    drop     = 1'b0;
    expire   = 1'b0;
    pick     = rr_pick(bus.req, last_q);
    xfer     = valid_q && bus.ready;
    at_dwell = (beat_q == DWELL_M1);

    unique case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        grant_d = 4'b0000;
        beat_d  = '0;
        if (pick[2]) begin
          state_d = GRANT;
          sel_d   = pick[1:0];
          last_d  = pick[1:0];
          grant_d = onehot(pick[1:0]);
          valid_d = 1'b1;
        end
      end

      GRANT: begin
        drop = !bus.req[sel_q];
`ifdef MUX_ARB_LOCK_EN
        expire = xfer && at_dwell && !bus.lock;
`else
        expire = xfer && at_dwell;
`endif
        if (drop || expire) begin
          // Re-arbitrate in the same cycle so consecutive grants have no bubble.
          beat_d = '0;
          if (pick[2]) begin
            sel_d   = pick[1:0];
            last_d  = pick[1:0];
            grant_d = onehot(pick[1:0]);
            valid_d = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = 4'b0000;
            valid_d = 1'b0;
          end
        end else if (xfer && !at_dwell) begin
          // Under lock the count saturates at DWELL-1 instead of expiring.
          beat_d = beat_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
        valid_d = 1'b0;
        beat_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      last_q  <= 2'd3;
      grant_q <= 4'b0000;
      valid_q <= 1'b0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      beat_q  <= beat_d;
    end
  end

  assign bus.sel   = sel_q;
  assign bus.grant = grant_q;
  assign bus.valid = valid_q;
  assign bus.beat  = beat_q;

endmodule

// File: tb/tb_mux_rr_sel_arbiter.sv
// Directed bench for mux_rr_sel_arbiter: one instance with DWELL=4 and one with DWELL=2.
module tb_mux_rr_sel_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mux_rr_sel_arbiter_if #(.CNT_W(8)) if_d4 ();
  mux_rr_sel_arbiter_if #(.CNT_W(8)) if_d2 ();

  mux_rr_sel_arbiter #(.DWELL(4), .CNT_W(8)) u_d4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_d4.master)
  );

  mux_rr_sel_arbiter #(.DWELL(2), .CNT_W(8)) u_d2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_d2.master)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_d4(input string tag, input logic [1:0] s, input logic v, input logic [7:0] b);
    chk({tag, ".sel"},   32'(if_d4.sel),   32'(s));
    chk({tag, ".grant"}, 32'(if_d4.grant), v ? 32'(4'b0001 << s) : 32'd0);
    chk({tag, ".valid"}, 32'(if_d4.valid), 32'(v));
    chk({tag, ".beat"},  32'(if_d4.beat),  32'(b));
  endtask

  task automatic chk_d2(input string tag, input logic [1:0] s, input logic v, input logic [7:0] b);
    chk({tag, ".sel"},   32'(if_d2.sel),   32'(s));
    chk({tag, ".grant"}, 32'(if_d2.grant), v ? 32'(4'b0001 << s) : 32'd0);
    chk({tag, ".valid"}, 32'(if_d2.valid), 32'(v));
    chk({tag, ".beat"},  32'(if_d2.beat),  32'(b));
  endtask

  initial begin
    logic [1:0] exp_sel [10] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
    if_d4.req = 4'b0000; if_d4.ready = 1'b0;
    if_d2.req = 4'b0000; if_d2.ready = 1'b0;
`ifdef MUX_ARB_LOCK_EN
    if_d4.lock = 1'b0;
    if_d2.lock = 1'b0;
`endif

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk_d4("rst_d4", 2'd0, 1'b0, 8'd0);
    chk_d2("rst_d2", 2'd0, 1'b0, 8'd0);

    // Test 1: async reset mid-grant
    if_d4.req = 4'b0100;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_d4("t1_grant2", 2'd2, 1'b1, 8'd0);
    rst_n = 1'b0;
    #1;
    chk_d4("t1_async_rst", 2'd0, 1'b0, 8'd0);
    if_d4.req = 4'b0001;
    #1 rst_n = 1'b1;
    step();
    chk_d4("t1_after_rst", 2'd0, 1'b1, 8'd0);
    chk_d2("t1_d2_idle", 2'd0, 1'b0, 8'd0);

    // Test 2: single requester, beat counts and wraps with no valid gap
    if_d4.ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk_d4($sformatf("t2_c%0d", i), 2'd0, 1'b1, 8'(i % 4));
    end

    // Test 4: sel=1 held while ready=0 and other requests toggle
    if_d4.req = 4'b0010;
    if_d4.ready = 1'b0;
    step();
    chk_d4("t4_grant1", 2'd1, 1'b1, 8'd0);
    for (int i = 0; i < 10; i++) begin
      if_d4.req = (i % 2 == 0) ? 4'b1010 : 4'b1110;
      step();
      chk_d4($sformatf("t4_hold%0d", i), 2'd1, 1'b1, 8'd0);
    end

    // Test 5: withdrawal hands over to next requester, then idle
    if_d4.req = 4'b1100;
    step();
    chk_d4("t5_grant2", 2'd2, 1'b1, 8'd0);
    if_d4.ready = 1'b1;
    step();
    chk_d4("t5_beat1", 2'd2, 1'b1, 8'd1);
    if_d4.req = 4'b1000;
    if_d4.ready = 1'b0;
    step();
    chk_d4("t5_grant3", 2'd3, 1'b1, 8'd0);
    if_d4.req = 4'b0000;
    step();
    chk_d4("t5_idle", 2'd3, 1'b0, 8'd0);
    step();
    chk_d4("t5_idle2", 2'd3, 1'b0, 8'd0);

    // Test 3: all requesting, DWELL=2 rotation
    if_d2.req = 4'b1111;
    if_d2.ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_d2($sformatf("t3_c%0d", i), exp_sel[i], 1'b1, 8'(i % 2));
    end

    // Dwell-final transfer coinciding with withdrawal: one release
    if_d2.req = 4'b1110;
    step();
    chk_d2("sim_release", 2'd1, 1'b1, 8'd0);

    // Back to idle, then grant source 0 with wrap-around search
    if_d2.req = 4'b0000;
    if_d2.ready = 1'b0;
    step();
    chk_d2("d2_idle", 2'd1, 1'b0, 8'd0);
    if_d2.req = 4'b0001;
    step();
    chk_d2("d2_wrap0", 2'd0, 1'b1, 8'd0);

`ifdef MUX_ARB_LOCK_EN
    // Test 6: lock suspends dwell expiry, beat saturates
    if_d2.req = 4'b0011;
    if_d2.lock = 1'b1;
    if_d2.ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk_d2($sformatf("t6_lock%0d", i), 2'd0, 1'b1, 8'd1);
    end
    if_d2.lock = 1'b0;
    step();
    chk_d2("t6_unlock", 2'd1, 1'b1, 8'd0);
`else
    // Same setup without lock: dwell expiry rotates to source 1
    if_d2.req = 4'b0011;
    if_d2.ready = 1'b1;
    step();
    chk_d2("t6_nolock_b1", 2'd0, 1'b1, 8'd1);
    step();
    chk_d2("t6_nolock_rot", 2'd1, 1'b1, 8'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
